// File: rtl/mpi_mem_bridge_if.sv
// mpi_mem_bridge_if: MPI local-bus signal bundle between a bus master and the
// mpi_mem_bridge register bank.
interface mpi_mem_bridge_if;
  logic        mpi_cs;
  logic        mpi_wren;
  logic        mpi_rden;
  logic [14:0] mpi_addr;
  logic [63:0] mpi_data_wr;
  logic [63:0] mpi_data_rd;
  logic        mpi_rd_rdy;

  modport master (
    output mpi_cs, mpi_wren, mpi_rden, mpi_addr, mpi_data_wr,
    input  mpi_data_rd, mpi_rd_rdy
  );

  modport slave (
    input  mpi_cs, mpi_wren, mpi_rden, mpi_addr, mpi_data_wr,
    output mpi_data_rd, mpi_rd_rdy
  );
endinterface

// File: rtl/mpi_mem_bridge.sv
// mpi_mem_bridge: 64-bit MPI register bank bridging to NUM_CH memory-controller channels.
// Define MPI_MEM_BRIDGE_TIMEOUT_EN to bound each channel's WAIT state by TIMEOUT_CYC cycles.
module mpi_mem_bridge #(
  parameter int          NUM_CH     = 2,
  parameter int          AW         = 25,
  parameter int          DW         = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter int          RD_LAT     = 8,
  parameter logic [14:0] CH_BASE    = 15'h70,
  parameter logic [63:0] VERSION    = 64'h0
`ifdef MPI_MEM_BRIDGE_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYC = 65535
`endif
) (
  input  logic                 clk_mpi,
  input  logic                 rst_mpi_n,
  mpi_mem_bridge_if.slave      mpi,
  output logic                 mpi_mem_local_ctrl_en,
  output logic [NUM_CH-1:0]    ch_start,
  output logic [NUM_CH-1:0]    ch_cmd,
  output logic [NUM_CH-1:0]    ch_chip_rst_n,
  output logic [NUM_CH*AW-1:0] ch_addr,
  output logic [NUM_CH*DW-1:0] ch_data_wr,
  input  logic [NUM_CH*DW-1:0] ch_data_rd,
  input  logic [NUM_CH-1:0]    ch_done,
  input  logic [NUM_CH-1:0]    ch_rdy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_CAPT} chState_e;

  logic                   wrEn;
  logic                   rdEn;
  logic                   inChWin;
  logic [14:0]            chOff;
  logic [10:0]            chIdx;
  logic [3:0]             chReg;
  logic [NUM_CH-1:0][63:0] chRdVal;
  logic [63:0]            rdMux;
  logic [63:0]            test_q;
  logic                   localCtrlEn_q;
  logic [63:0]            rdData_q;
  logic                   rdRdy_q;
  logic [RD_LAT-1:0]      csShift_q;

  // Channel window: each channel owns a 16-register block starting at CH_BASE.
  always_comb begin
    wrEn    = mpi.mpi_cs & mpi.mpi_wren;
    rdEn    = mpi.mpi_cs & mpi.mpi_rden;
    inChWin = (mpi.mpi_addr >= CH_BASE);
    chOff   = mpi.mpi_addr - CH_BASE;
    chIdx   = chOff[14:4];
    chReg   = chOff[3:0];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          sel;
    logic          ctrlWr;
    logic          cmdWr;
    logic          popReq;
    chState_e      state_q;
    logic          cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          start_q;
    logic          chipRstN_q;
    logic          clrPend_q;
    logic          doneDly_q;
    logic          ovf_q;
    logic          busyErr_q;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic          doneRise;
    logic          pushReq;
    logic          doPush;
    logic          doPop;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          tmoHit;
    logic          tmoFlag;
    logic [63:0]   rdVal;

    assign sel      = inChWin && (chIdx == 11'(c));
    assign ctrlWr   = wrEn && sel && (chReg == 4'd0);
    assign cmdWr    = wrEn && sel && (chReg == 4'd1);
    assign popReq   = rdEn && sel && (chReg == 4'd2);
    assign doneRise = ch_done[c] & ~doneDly_q;

    // A pending clear beats any push or pop landing in the same cycle.
    always_comb begin
      fifoEmpty = (count_q == '0);
      fifoFull  = (count_q == CW'(FIFO_DEPTH));
      doPop     = popReq && !fifoEmpty;
      pushReq   = (state_q == ST_CAPT) && cmd_q;
      doPush    = pushReq && (!fifoFull || doPop);
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      count_d   = count_q;
      if (clrPend_q) begin
        wrPtr_d = '0;
        rdPtr_d = '0;
        count_d = '0;
      end else begin
        if (doPush) wrPtr_d = (wrPtr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = (rdPtr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
        count_d = count_q + CW'(doPush) - CW'(doPop);
      end
    end

    always_ff @(posedge clk_mpi) begin
      if (doPush && !clrPend_q) mem_q[wrPtr_q] <= ch_data_rd[c*DW +: DW];
    end

    always_ff @(posedge clk_mpi) begin
      if (!rst_mpi_n) begin
        state_q    <= ST_IDLE;
        cmd_q      <= 1'b0;
        addr_q     <= '0;
        wdata_q    <= '0;
        start_q    <= 1'b0;
        chipRstN_q <= 1'b1;
        clrPend_q  <= 1'b0;
        doneDly_q  <= 1'b0;
        ovf_q      <= 1'b0;
        busyErr_q  <= 1'b0;
        wrPtr_q    <= '0;
        rdPtr_q    <= '0;
        count_q    <= '0;
      end else begin
        doneDly_q <= ch_done[c];
        start_q   <= 1'b0;
        clrPend_q <= ctrlWr && mpi.mpi_data_wr[1];
        wrPtr_q   <= wrPtr_d;
        rdPtr_q   <= rdPtr_d;
        count_q   <= count_d;
        if (ctrlWr) begin
          chipRstN_q <= mpi.mpi_data_wr[0];
          if (mpi.mpi_data_wr[8]) begin
            ovf_q     <= 1'b0;
            busyErr_q <= 1'b0;
          end
        end
        if (cmdWr && state_q != ST_IDLE) busyErr_q <= 1'b1;
        if (pushReq && !doPush && !clrPend_q) ovf_q <= 1'b1;
        case (state_q)
          ST_IDLE: if (cmdWr) begin
            cmd_q   <= mpi.mpi_data_wr[60];
            addr_q  <= mpi.mpi_data_wr[32 +: AW];
            wdata_q <= mpi.mpi_data_wr[DW-1:0];
            start_q <= 1'b1;
            state_q <= ST_REQ;
          end
          ST_REQ:  state_q <= ST_WAIT;
          ST_WAIT: begin
            if (doneRise)    state_q <= ST_CAPT;
            else if (tmoHit) state_q <= ST_IDLE;
          end
          ST_CAPT: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end

`ifdef MPI_MEM_BRIDGE_TIMEOUT_EN
    logic [15:0] tmoCnt_q;
    logic        tmo_q;

    assign tmoHit  = (state_q == ST_WAIT) && (tmoCnt_q == 16'(TIMEOUT_CYC));
    assign tmoFlag = tmo_q;

    always_ff @(posedge clk_mpi) begin
      if (!rst_mpi_n) begin
        tmoCnt_q <= '0;
        tmo_q    <= 1'b0;
      end else begin
        if (state_q == ST_REQ) tmoCnt_q <= '0;
        else if (state_q == ST_WAIT && !doneRise && !tmoHit) tmoCnt_q <= tmoCnt_q + 16'd1;
        if (ctrlWr && mpi.mpi_data_wr[8]) tmo_q <= 1'b0;
        if (tmoHit && !doneRise) tmo_q <= 1'b1;
      end
    end
`else
    assign tmoHit  = 1'b0;
    assign tmoFlag = 1'b0;
`endif

    always_comb begin
      rdVal = '0;
      case (chReg)
        4'd0: begin
          rdVal[31:16] = 16'(count_q);
          rdVal[7]     = ovf_q;
          rdVal[6]     = busyErr_q;
          rdVal[5]     = ch_rdy[c];
          rdVal[4]     = ch_done[c];
          rdVal[3]     = tmoFlag;
          rdVal[2]     = (state_q != ST_IDLE);
          rdVal[0]     = chipRstN_q;
        end
        4'd1: begin
          rdVal[60]        = cmd_q;
          rdVal[32 +: AW]  = addr_q;
          rdVal[DW-1:0]    = wdata_q;
        end
        4'd2: if (!fifoEmpty) rdVal[DW-1:0] = mem_q[rdPtr_q];
        default: rdVal = '0;
      endcase
    end

    assign chRdVal[c]              = sel ? rdVal : '0;
    assign ch_start[c]             = start_q;
    assign ch_cmd[c]               = cmd_q;
    assign ch_chip_rst_n[c]        = chipRstN_q;
    assign ch_addr[c*AW +: AW]     = addr_q;
    assign ch_data_wr[c*DW +: DW]  = wdata_q;
  end

  // Channel contributions are already zero unless selected, so OR them together.
  always_comb begin
    rdMux = '0;
    case (mpi.mpi_addr)
      15'h0: rdMux = VERSION;
      15'h1: rdMux = test_q;
      15'h2: rdMux = {63'b0, localCtrlEn_q};
      default: for (int c = 0; c < NUM_CH; c++) rdMux = rdMux | chRdVal[c];
    endcase
  end

  always_ff @(posedge clk_mpi) begin
    if (!rst_mpi_n) begin
      test_q        <= '0;
      localCtrlEn_q <= 1'b0;
      rdData_q      <= '0;
      rdRdy_q       <= 1'b0;
      csShift_q     <= '0;
    end else begin
      if (wrEn && mpi.mpi_addr == 15'h1) test_q <= mpi.mpi_data_wr;
      if (wrEn && mpi.mpi_addr == 15'h2) localCtrlEn_q <= mpi.mpi_data_wr[0];
      rdData_q  <= rdMux;
      csShift_q <= (csShift_q << 1) | RD_LAT'(mpi.mpi_cs);
      rdRdy_q   <= mpi.mpi_rden & csShift_q[RD_LAT-1];
    end
  end

  assign mpi.mpi_data_rd       = rdData_q;
  assign mpi.mpi_rd_rdy        = rdRdy_q;
  assign mpi_mem_local_ctrl_en = localCtrlEn_q;

endmodule

// File: tb/tb_mpi_mem_bridge.sv
// tb_mpi_mem_bridge: directed bench for mpi_mem_bridge with hand-computed expectations.
module tb_mpi_mem_bridge;

  localparam logic [63:0] VERSION_T = 64'hA5A5_0000_1234_5678;

  logic        clk_mpi = 1'b0;
  logic        rst_mpi_n = 1'b0;
  logic        localCtrlEn;
  logic [1:0]  chStart;
  logic [1:0]  chCmd;
  logic [1:0]  chChipRstN;
  logic [49:0] chAddr;
  logic [63:0] chDataWr;
  logic [63:0] chDataRd = '0;
  logic [1:0]  chDone = '0;
  logic [1:0]  chRdy = 2'b10;
  logic [63:0] rdVal;
  int          checkCount = 0;
  int          passCount = 0;

  mpi_mem_bridge_if mpiBus();

  mpi_mem_bridge #(
    .VERSION(VERSION_T)
`ifdef MPI_MEM_BRIDGE_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk_mpi(clk_mpi),
    .rst_mpi_n(rst_mpi_n),
    .mpi(mpiBus),
    .mpi_mem_local_ctrl_en(localCtrlEn),
    .ch_start(chStart),
    .ch_cmd(chCmd),
    .ch_chip_rst_n(chChipRstN),
    .ch_addr(chAddr),
    .ch_data_wr(chDataWr),
    .ch_data_rd(chDataRd),
    .ch_done(chDone),
    .ch_rdy(chRdy)
  );

  always #5 clk_mpi = ~clk_mpi;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic cs, input logic wren, input logic rden,
                               input logic [14:0] addr, input logic [63:0] data);
    mpiBus.mpi_cs      = cs;
    mpiBus.mpi_wren    = wren;
    mpiBus.mpi_rden    = rden;
    mpiBus.mpi_addr    = addr;
    mpiBus.mpi_data_wr = data;
    @(posedge clk_mpi);
    #1;
  endtask

  task automatic driveIdle();
    mpiBus.mpi_cs      = 1'b0;
    mpiBus.mpi_wren    = 1'b0;
    mpiBus.mpi_rden    = 1'b0;
    mpiBus.mpi_addr    = '0;
    mpiBus.mpi_data_wr = '0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 15'h0, 64'h0);
  endtask

  task automatic busWrite(input logic [14:0] addr, input logic [63:0] data);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, data);
    driveIdle();
  endtask

  task automatic checkRead(input string tag, input logic [14:0] addr, input logic [63:0] expected);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, 64'h0);
    rdVal = mpiBus.mpi_data_rd;
    driveIdle();
    checkOutput(tag, rdVal, expected);
  endtask

  function automatic logic [63:0] cmdWord(input logic rd, input logic [24:0] a, input logic [31:0] d);
    return {3'b000, rd, 3'b000, a, d};
  endfunction

  // Full read command: CMD write, one cycle to WAIT, done high for the detect and capture cycles.
  task automatic runRead(input int ch, input logic [24:0] a, input logic [31:0] d);
    busWrite(ch == 0 ? 15'h71 : 15'h81, cmdWord(1'b1, a, d));
    idleCycles(1);
    chDone[ch] = 1'b1;
    chDataRd[ch*32 +: 32] = d;
    idleCycles(2);
    chDone[ch] = 1'b0;
    idleCycles(1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    driveIdle();
    idleCycles(3);
    checkOutput("reset chip_rst_n", {62'b0, chChipRstN}, 64'h3);
    checkOutput("reset ch_start", {62'b0, chStart}, 64'h0);
    checkOutput("reset rd_rdy", {63'b0, mpiBus.mpi_rd_rdy}, 64'h0);
    checkOutput("reset local_ctrl_en", {63'b0, localCtrlEn}, 64'h0);
    checkOutput("reset data_rd", mpiBus.mpi_data_rd, 64'h0);
    rst_mpi_n = 1'b1;

    checkRead("version", 15'h00, VERSION_T);
    busWrite(15'h01, 64'h1234);
    checkRead("test reg 0x1234", 15'h01, 64'h1234);
    busWrite(15'h01, 64'hFEDC_BA98_7654_3210);
    checkRead("test reg full width", 15'h01, 64'hFEDC_BA98_7654_3210);
    busWrite(15'h02, 64'h1);
    checkOutput("local_ctrl_en set", {63'b0, localCtrlEn}, 64'h1);
    checkRead("local ctrl reg", 15'h02, 64'h1);
    checkRead("unmapped read", 15'h50, 64'h0);
    busWrite(15'h91, cmdWord(1'b1, 25'h1, 32'h1));
    checkOutput("no start for ch2", {62'b0, chStart}, 64'h0);
    checkRead("ch2 stat reads 0", 15'h90, 64'h0);

    // mpi_rd_rdy needs cs sampled high RD_LAT edges earlier
    idleCycles(10);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 15'h00, 64'h0);
      if (k == 8) checkOutput("rd_rdy before latency", {63'b0, mpiBus.mpi_rd_rdy}, 64'h0);
    end
    checkOutput("rd_rdy after latency", {63'b0, mpiBus.mpi_rd_rdy}, 64'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h00, 64'h0);
    checkOutput("rd_rdy needs rden", {63'b0, mpiBus.mpi_rd_rdy}, 64'h0);
    driveIdle();

    // Channel 1 read command
    busWrite(15'h81, cmdWord(1'b1, 25'h0ABCDE, 32'h0));
    checkOutput("ch1 start pulse", {62'b0, chStart}, 64'h2);
    checkOutput("ch1 addr", {39'b0, chAddr[49:25]}, 64'h0ABCDE);
    checkOutput("ch1 cmd", {63'b0, chCmd[1]}, 64'h1);
    idleCycles(1);
    checkOutput("ch1 start one cycle", {62'b0, chStart}, 64'h0);
    checkRead("ch1 stat busy", 15'h80, 64'h25);
    chDone[1] = 1'b1;
    chDataRd[63:32] = 32'hDEADBEEF;
    idleCycles(2);
    chDone[1] = 1'b0;
    checkRead("ch1 stat count1", 15'h80, 64'h0001_0021);
    checkRead("ch1 cmd readback", 15'h81, cmdWord(1'b1, 25'h0ABCDE, 32'h0));
    checkRead("ch1 rdata", 15'h82, 64'hDEADBEEF);
    checkRead("ch1 stat count0", 15'h80, 64'h21);
    checkRead("ch1 rdata empty", 15'h82, 64'h0);

    // Channel 1 write command: no push
    busWrite(15'h81, cmdWord(1'b0, 25'h12, 32'hCAFEF00D));
    checkOutput("ch1 data_wr", {32'b0, chDataWr[63:32]}, 64'hCAFEF00D);
    checkOutput("ch1 cmd write", {63'b0, chCmd[1]}, 64'h0);
    idleCycles(1);
    chDone[1] = 1'b1;
    idleCycles(2);
    chDone[1] = 1'b0;
    checkRead("ch1 write no push", 15'h80, 64'h21);

    // Busy write on channel 0
    busWrite(15'h71, cmdWord(1'b1, 25'h1111, 32'h0));
    idleCycles(1);
    busWrite(15'h71, cmdWord(1'b1, 25'h2222, 32'h0));
    checkOutput("ch0 addr unchanged", {39'b0, chAddr[24:0]}, 64'h1111);
    checkRead("ch0 busy error", 15'h70, 64'h45);
    busWrite(15'h70, 64'h101);
    checkRead("ch0 busy error cleared", 15'h70, 64'h05);
    chDone[0] = 1'b1;
    chDataRd[31:0] = 32'hC0DE_0000;
    idleCycles(2);
    chDone[0] = 1'b0;
    idleCycles(1);

    // FIFO full: 17 pushes total into a 16-deep FIFO
    for (int k = 1; k <= 16; k++) runRead(0, 25'(k), 32'hC0DE_0000 + 32'(k));
    checkRead("ch0 full overflow", 15'h70, 64'h0010_0081);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 15'h72, 64'h0);
      rdVal = mpiBus.mpi_data_rd;
      driveIdle();
      checkOutput($sformatf("ch0 pop %0d", k), rdVal, 64'hC0DE_0000 + 64'(k));
    end
    checkRead("ch0 drained", 15'h70, 64'h81);
    busWrite(15'h70, 64'h101);
    checkRead("ch0 overflow cleared", 15'h70, 64'h01);

    // Clear pending in the same cycle as a push: clear wins
    runRead(0, 25'h5, 32'h1234);
    checkRead("ch0 count before clear", 15'h70, 64'h0001_0001);
    busWrite(15'h71, cmdWord(1'b1, 25'h6, 32'h0));
    idleCycles(1);
    chDone[0] = 1'b1;
    chDataRd[31:0] = 32'h5555;
    busWrite(15'h70, 64'h3);
    idleCycles(1);
    chDone[0] = 1'b0;
    checkRead("clear beats push", 15'h70, 64'h01);
    checkRead("cleared rdata", 15'h72, 64'h0);

    // WAIT with no done
    busWrite(15'h81, cmdWord(1'b1, 25'h33, 32'h0));
    idleCycles(110);
`ifdef MPI_MEM_BRIDGE_TIMEOUT_EN
    checkRead("timeout flag", 15'h80, 64'h29);
    busWrite(15'h80, 64'h101);
    checkRead("timeout cleared", 15'h80, 64'h21);
`else
    checkRead("wait unbounded", 15'h80, 64'h25);
    chDone[1] = 1'b1;
    chDataRd[63:32] = 32'h0BADF00D;
    idleCycles(2);
    chDone[1] = 1'b0;
    checkRead("late done pushes", 15'h80, 64'h0001_0021);
    checkRead("late done rdata", 15'h82, 64'h0BADF00D);
`endif

    // Mid-operation reset
    busWrite(15'h80, 64'h0);
    checkOutput("ch1 chip rst low", {62'b0, chChipRstN}, 64'h1);
    busWrite(15'h71, cmdWord(1'b0, 25'h77, 32'h0));
    checkOutput("ch0 start before reset", {62'b0, chStart}, 64'h1);
    rst_mpi_n = 1'b0;
    idleCycles(1);
    checkOutput("reset kills start", {62'b0, chStart}, 64'h0);
    checkOutput("reset chip rst high", {62'b0, chChipRstN}, 64'h3);
    rst_mpi_n = 1'b1;
    idleCycles(2);
    checkOutput("no start after reset", {62'b0, chStart}, 64'h0);
    checkRead("ch0 idle after reset", 15'h70, 64'h01);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
